blackjack_game_fsm: RTL and testbench
=====================================

Name: blackjack_game_fsm

Overview:
- Round controller directly upstream of the seven-segment/LED output stage; produces the `hand`-typed playerHand and dealerHand values and the `gameState` value that stage consumes.
- Requests cards from the card source over a valid/req handshake and accumulates player and dealer hand values with soft-ace handling.
- Sequences deal, player turn, dealer draw-to-17 and result states from debounced deal/hit/stand pulses.

Parameters:
- DEALER_STAND, 17, dealer stops drawing when hand value >= this (soft 17 stands).
- BLACKJACK, 21, target and bust threshold (bust when value > BLACKJACK).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- deal  in  1  one-cycle pulse: start a new round (accepted in S_RESET and in any S_RESULT_* state)
- hit  in  1  one-cycle pulse: player takes a card (S_PLAYER_TURN only)
- stand  in  1  one-cycle pulse: player ends turn (S_PLAYER_TURN only)
- card_value  in  4  card from source: 1=ace, 2..10, faces already mapped to 10
- card_valid  in  1  card_value valid this cycle
- card_req  out  1  FSM wants a card; held high until accepted
- playerHand  out  `hand (5)  player hand value, aces counted soft where legal
- dealerHand  out  `hand (5)  dealer hand value, same rule
- gameState  out  `gameState  current state

Behaviour:
- Reset (synchronous, takes priority over everything, including mid-handshake): gameState=S_RESET, playerHand=0, dealerHand=0, card_req=0, internal sums/ace flags/card counter=0.
- Handshake: card accepted on a rising edge where card_req && card_valid. card_req deasserts in the cycle after acceptance. card_valid without card_req is ignored. card_value 0 is treated as 1; values 11..15 are clamped to 10.
- Hand rule: raw = sum of cards with ace=1; value = raw+10 if the hand holds an ace and raw <= 11, else raw. The registered hand output updates on the acceptance edge. Max reachable value is 30, so 5 bits never overflow.
- States and transitions; decisions always use the registered (already updated) hands, one cycle after acceptance:
  - S_RESET: on deal, clear both hands and go to S_DEAL_PLAYER.
  - S_DEAL_PLAYER: card_req=1. Accept 2 cards into the player hand (2-bit counter), then go to S_DEAL_DEALER.
  - S_DEAL_DEALER: card_req=1. Accept 1 card into the dealer hand, then go to S_CHECK_BLJK.
  - S_CHECK_BLJK (1 cycle): if playerHand==BLACKJACK go to S_RESULT_BLJK, else S_PLAYER_TURN.
  - S_PLAYER_TURN: card_req=0. If stand, go to S_DRAW_TO_17. Else if hit, go to S_PLAYER_HIT. If hit and stand arrive together, stand wins.
  - S_PLAYER_HIT: card_req=1. Accept 1 card into the player hand, then go to S_CHECK_BUST.
  - S_CHECK_BUST (1 cycle): if playerHand > BLACKJACK go to S_RESULT_BUST; if playerHand == BLACKJACK go to S_DRAW_TO_17; else S_PLAYER_TURN.
  - S_DRAW_TO_17: if dealerHand >= DEALER_STAND go to S_COMPARE with no request. Else card_req=1, accept 1 card, and re-evaluate on the following cycle.
  - S_COMPARE (1 cycle): dealer > BLACKJACK gives S_RESULT_WIN; player > dealer gives WIN; equal gives S_RESULT_TIE; otherwise S_RESULT_LOSE.
  - S_RESULT_*: hold state and both hands until deal. On deal, clear hands and go to S_DEAL_PLAYER. hit and stand are ignored.
- deal, hit and stand outside the states listed above are ignored, with no side effects.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- gameState.svh holds every `S_*` constant above, shared with the output stage. The enumeration is extended with S_DEAL_PLAYER, S_CHECK_BLJK, S_PLAYER_TURN, S_PLAYER_HIT, S_CHECK_BUST and S_COMPARE. S_RESET, S_DEAL_DEALER, S_DRAW_TO_17 and S_RESULT_WIN/LOSE/TIE/BUST/BLJK keep their existing encodings.
- hand.svh holds the `hand` width (5).
- Sub-module hand_accumulator, instantiated twice:
  - Inputs: clk, reset, clear, add, card.
  - Output: registered soft-ace value.

Test Plan:
- Cards 1,10 to player then 5 to dealer → S_CHECK_BLJK then S_RESULT_BLJK; playerHand=21, dealerHand=5.
- Player 10,6; dealer 9; stand; dealer draws 8 → dealerHand=17, S_COMPARE → S_RESULT_LOSE; dealer card 9 instead → dealerHand=18, S_RESULT_LOSE; with player 10,9 and dealer 9,9 → S_RESULT_TIE.
- Player 10,6, hit with card 10 → playerHand=26 → S_RESULT_BUST, dealer never receives a card (card_req stays 0).
- Soft ace: player 1,5 (16), hit with 10 → playerHand=16 (hard), remains S_PLAYER_TURN. Dealer 1,6 → soft 17 stands with no further card_req.
- Handshake and clamping:
  - card_valid delayed 5 cycles → card_req held high all 5 cycles, exactly one card accepted.
  - card_valid while card_req=0 → no hand change.
  - card_value 13 → counted as 10.
- Reset asserted mid-S_DRAW_TO_17 with card_req=1 → next cycle gameState=S_RESET, both hands 0, card_req=0.
- hit and stand in the same cycle in S_PLAYER_TURN → S_DRAW_TO_17.

Source files
------------

// File: rtl/blackjack_game_fsm_pkg.sv
// rtl/blackjack_game_fsm_pkg.sv - shared hand/state types and card normalisation for the blackjack round controller
package blackjack_game_fsm_pkg;

    localparam int HAND_W = 5;

    typedef logic [HAND_W-1:0] hand_t;

    // Original encodings (0..7) are shared with the output stage; new states are appended.
    typedef enum logic [3:0] {
        S_RESET       = 4'd0,
        S_DEAL_DEALER = 4'd1,
        S_DRAW_TO_17  = 4'd2,
        S_RESULT_WIN  = 4'd3,
        S_RESULT_LOSE = 4'd4,
        S_RESULT_TIE  = 4'd5,
        S_RESULT_BUST = 4'd6,
        S_RESULT_BLJK = 4'd7,
        S_DEAL_PLAYER = 4'd8,
        S_CHECK_BLJK  = 4'd9,
        S_PLAYER_TURN = 4'd10,
        S_PLAYER_HIT  = 4'd11,
        S_CHECK_BUST  = 4'd12,
        S_COMPARE     = 4'd13
    } game_state_t;

    function automatic logic [3:0] norm_card(input logic [3:0] v);
        if (v == 4'd0) begin
            return 4'd1;
        end else if (v > 4'd10) begin
            return 4'd10;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/blackjack_game_fsm_hand_accumulator.sv
// rtl/blackjack_game_fsm_hand_accumulator.sv - running hand total with a registered soft-ace value
module hand_accumulator
    import blackjack_game_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       add,
    input  logic [3:0] card,
    output hand_t      value
);

    hand_t raw_q, raw_d;
    logic  ace_q, ace_d;
    hand_t value_q, value_d;
    logic [3:0] card_n;

    assign card_n = norm_card(card);

    always_comb begin
        raw_d = raw_q;
        ace_d = ace_q;
        if (clear) begin
            raw_d = '0;
            ace_d = 1'b0;
        end else if (add) begin
            raw_d = raw_q + {1'b0, card_n};
            ace_d = ace_q | (card_n == 4'd1);
        end
        // One ace may count as 11 only while that keeps the hand at or below 21.
        value_d = (ace_d && (raw_d <= 5'd11)) ? raw_d + 5'd10 : raw_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q   <= '0;
            ace_q   <= 1'b0;
            value_q <= '0;
        end else begin
            raw_q   <= raw_d;
            ace_q   <= ace_d;
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/blackjack_game_fsm.sv
// rtl/blackjack_game_fsm.sv - blackjack round sequencer with card request handshake
module blackjack_game_fsm
    import blackjack_game_fsm_pkg::*;
#(
    parameter int unsigned DEALER_STAND = 17,
    parameter int unsigned BLACKJACK    = 21
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        deal,
    input  logic        hit,
    input  logic        stand,
    input  logic [3:0]  card_value,
    input  logic        card_valid,
    output logic        card_req,
    output hand_t       playerHand,
    output hand_t       dealerHand,
    output game_state_t gameState
);

    localparam hand_t STAND_H = hand_t'(DEALER_STAND);
    localparam hand_t BJ_H    = hand_t'(BLACKJACK);

    game_state_t state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        card_req_q, card_req_d;
    logic        accept;
    logic        p_clear, p_add, d_clear, d_add;
    hand_t       player_v, dealer_v;

    assign accept = card_req_q && card_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_clear = 1'b0;
        p_add   = 1'b0;
        d_clear = 1'b0;
        d_add   = 1'b0;
        case (state_q)
            S_RESET, S_RESULT_WIN, S_RESULT_LOSE, S_RESULT_TIE, S_RESULT_BUST, S_RESULT_BLJK: begin
                if (deal) begin
                    p_clear = 1'b1;
                    d_clear = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = S_DEAL_PLAYER;
                end
            end
            S_DEAL_PLAYER: begin
                if (accept) begin
                    p_add = 1'b1;
                    if (cnt_q == 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = S_DEAL_DEALER;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_DEAL_DEALER: begin
                if (accept) begin
                    d_add   = 1'b1;
                    state_d = S_CHECK_BLJK;
                end
            end
            S_CHECK_BLJK: begin
                state_d = (player_v == BJ_H) ? S_RESULT_BLJK : S_PLAYER_TURN;
            end
            S_PLAYER_TURN: begin
                if (stand) begin
                    state_d = S_DRAW_TO_17;
                end else if (hit) begin
                    state_d = S_PLAYER_HIT;
                end
            end
            S_PLAYER_HIT: begin
                if (accept) begin
                    p_add   = 1'b1;
                    state_d = S_CHECK_BUST;
                end
            end
            S_CHECK_BUST: begin
                if (player_v > BJ_H) begin
                    state_d = S_RESULT_BUST;
                end else if (player_v == BJ_H) begin
                    state_d = S_DRAW_TO_17;
                end else begin
                    state_d = S_PLAYER_TURN;
                end
            end
            S_DRAW_TO_17: begin
                // A request is only ever raised while the dealer is below the stand value.
                if (accept) begin
                    d_add = 1'b1;
                end else if (dealer_v >= STAND_H) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (dealer_v > BJ_H || player_v > dealer_v) begin
                    state_d = S_RESULT_WIN;
                end else if (player_v == dealer_v) begin
                    state_d = S_RESULT_TIE;
                end else begin
                    state_d = S_RESULT_LOSE;
                end
            end
            default: state_d = S_RESET;
        endcase

        // Request drops for one cycle after each acceptance so the next decision sees the updated hand.
        card_req_d = !accept &&
                     ((state_d == S_DEAL_PLAYER) || (state_d == S_DEAL_DEALER) ||
                      (state_d == S_PLAYER_HIT) ||
                      ((state_q == S_DRAW_TO_17) && (state_d == S_DRAW_TO_17) && (dealer_v < STAND_H)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RESET;
            cnt_q      <= 2'd0;
            card_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            card_req_q <= card_req_d;
        end
    end

    hand_accumulator u_player (
        .clk   (clk),
        .reset (reset),
        .clear (p_clear),
        .add   (p_add),
        .card  (card_value),
        .value (player_v)
    );

    hand_accumulator u_dealer (
        .clk   (clk),
        .reset (reset),
        .clear (d_clear),
        .add   (d_add),
        .card  (card_value),
        .value (dealer_v)
    );

    assign card_req   = card_req_q;
    assign playerHand = player_v;
    assign dealerHand = dealer_v;
    assign gameState  = state_q;

endmodule

// File: tb/tb_blackjack_game_fsm.sv
// tb/tb_blackjack_game_fsm.sv - scoreboard bench for the blackjack round controller
module tb_blackjack_game_fsm;
    import blackjack_game_fsm_pkg::*;

    logic        clk = 1'b0;
    logic        reset, deal, hit, stand, card_valid;
    logic [3:0]  card_value;
    logic        card_req;
    hand_t       playerHand, dealerHand;
    game_state_t gameState;

    typedef struct packed {
        game_state_t st;
        hand_t       p;
        hand_t       d;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    game_state_t last_st = S_RESET;

    always #5 clk = ~clk;

    blackjack_game_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .deal       (deal),
        .hit        (hit),
        .stand      (stand),
        .card_value (card_value),
        .card_valid (card_valid),
        .card_req   (card_req),
        .playerHand (playerHand),
        .dealerHand (dealerHand),
        .gameState  (gameState)
    );

    task automatic chk(input bit ok, input string name, input int act, input int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    // Monitor: every state change must match the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && gameState != last_st) begin
            last_st = gameState;
            if (sb_q.size() == 0) begin
                chk(1'b0, "unexpected_state", int'(gameState), 0);
            end else begin
                e = sb_q.pop_front();
                chk(gameState == e.st, "state", int'(gameState), int'(e.st));
                chk(playerHand == e.p, "player_hand", int'(playerHand), int'(e.p));
                chk(dealerHand == e.d, "dealer_hand", int'(dealerHand), int'(e.d));
            end
        end
    end

    task automatic expect_st(input game_state_t s, input int p, input int d);
        exp_t e;
        e.st = s;
        e.p  = hand_t'(p);
        e.d  = hand_t'(d);
        sb_q.push_back(e);
    endtask

    task automatic pulse_deal();
        deal = 1'b1;
        @(negedge clk);
        deal = 1'b0;
    endtask

    task automatic pulse_hit_stand(input bit h, input bit s);
        hit   = h;
        stand = s;
        @(negedge clk);
        hit   = 1'b0;
        stand = 1'b0;
    endtask

    task automatic give_card(input int v, input int dly);
        int n = 0;
        while (!card_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!card_req) begin
            chk(1'b0, "card_req_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk(card_req == 1'b1, "req_held", int'(card_req), 1);
        end
        card_value = 4'(v);
        card_valid = 1'b1;
        @(negedge clk);
        card_valid = 1'b0;
        chk(card_req == 1'b0, "req_drop", int'(card_req), 0);
    endtask

    task automatic wait_state(input game_state_t s);
        int n = 0;
        while (gameState != s && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(gameState == s, "wait_state", int'(gameState), int'(s));
    endtask

    task automatic no_req(input int cycles, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (card_req) seen = 1'b1;
        end
        chk(!seen, name, int'(seen), 0);
    endtask

    task automatic start_round(input int c1, input int c2, input int d1, input int pv, input int dv);
        expect_st(S_DEAL_PLAYER, 0, 0);
        expect_st(S_DEAL_DEALER, pv, 0);
        expect_st(S_CHECK_BLJK, pv, dv);
        expect_st(S_PLAYER_TURN, pv, dv);
        pulse_deal();
        give_card(c1, 0);
        give_card(c2, 0);
        give_card(d1, 0);
        wait_state(S_PLAYER_TURN);
    endtask

    initial begin
        int n;
        reset = 1'b1; deal = 1'b0; hit = 1'b0; stand = 1'b0;
        card_valid = 1'b0; card_value = 4'd0;
        repeat (3) @(negedge clk);
        chk(gameState == S_RESET, "reset_state", int'(gameState), int'(S_RESET));
        chk(playerHand == 0, "reset_player", int'(playerHand), 0);
        chk(dealerHand == 0, "reset_dealer", int'(dealerHand), 0);
        chk(card_req == 1'b0, "reset_req", int'(card_req), 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Blackjack: delayed first card, face card encoded as 13.
        expect_st(S_DEAL_PLAYER, 0, 0);
        expect_st(S_DEAL_DEALER, 21, 0);
        expect_st(S_CHECK_BLJK, 21, 5);
        expect_st(S_RESULT_BLJK, 21, 5);
        pulse_deal();
        give_card(1, 5);
        chk(playerHand == 11, "one_card_accepted", int'(playerHand), 11);
        give_card(13, 0);
        give_card(5, 0);
        wait_state(S_RESULT_BLJK);

        // Dealer lands on hard 17; stray card_valid while idle is ignored.
        start_round(10, 6, 9, 16, 9);
        card_value = 4'd5;
        card_valid = 1'b1;
        @(negedge clk);
        card_valid = 1'b0;
        chk(playerHand == 16, "stray_valid_player", int'(playerHand), 16);
        chk(dealerHand == 9, "stray_valid_dealer", int'(dealerHand), 9);
        expect_st(S_DRAW_TO_17, 16, 9);
        expect_st(S_COMPARE, 16, 17);
        expect_st(S_RESULT_LOSE, 16, 17);
        pulse_hit_stand(1'b0, 1'b1);
        give_card(8, 0);
        wait_state(S_RESULT_LOSE);

        start_round(10, 6, 9, 16, 9);
        expect_st(S_DRAW_TO_17, 16, 9);
        expect_st(S_COMPARE, 16, 18);
        expect_st(S_RESULT_LOSE, 16, 18);
        pulse_hit_stand(1'b0, 1'b1);
        give_card(9, 0);
        wait_state(S_RESULT_LOSE);

        start_round(10, 9, 9, 19, 9);
        expect_st(S_DRAW_TO_17, 19, 9);
        expect_st(S_COMPARE, 19, 19);
        expect_st(S_RESULT_TIE, 19, 19);
        pulse_hit_stand(1'b0, 1'b1);
        give_card(10, 0);
        wait_state(S_RESULT_TIE);

        // Player bust: dealer must never be asked for a card.
        start_round(10, 6, 7, 16, 7);
        expect_st(S_PLAYER_HIT, 16, 7);
        expect_st(S_CHECK_BUST, 26, 7);
        expect_st(S_RESULT_BUST, 26, 7);
        pulse_hit_stand(1'b1, 1'b0);
        give_card(10, 0);
        wait_state(S_RESULT_BUST);
        no_req(10, "no_req_after_bust");

        // Soft ace becomes hard; simultaneous hit+stand stands; dealer soft 17 stands.
        start_round(1, 5, 1, 16, 11);
        expect_st(S_PLAYER_HIT, 16, 11);
        expect_st(S_CHECK_BUST, 16, 11);
        expect_st(S_PLAYER_TURN, 16, 11);
        pulse_hit_stand(1'b1, 1'b0);
        give_card(10, 0);
        wait_state(S_PLAYER_TURN);
        expect_st(S_DRAW_TO_17, 16, 11);
        expect_st(S_COMPARE, 16, 17);
        expect_st(S_RESULT_LOSE, 16, 17);
        pulse_hit_stand(1'b1, 1'b1);
        give_card(6, 0);
        wait_state(S_RESULT_LOSE);
        no_req(5, "no_req_soft17");

        // Hit to exactly 21 goes straight to the dealer.
        start_round(10, 5, 10, 15, 10);
        expect_st(S_PLAYER_HIT, 15, 10);
        expect_st(S_CHECK_BUST, 21, 10);
        expect_st(S_DRAW_TO_17, 21, 10);
        expect_st(S_COMPARE, 21, 17);
        expect_st(S_RESULT_WIN, 21, 17);
        pulse_hit_stand(1'b1, 1'b0);
        give_card(6, 0);
        give_card(7, 0);
        wait_state(S_RESULT_WIN);

        // Dealer draws twice and busts.
        start_round(10, 10, 6, 20, 6);
        expect_st(S_DRAW_TO_17, 20, 6);
        expect_st(S_COMPARE, 20, 26);
        expect_st(S_RESULT_WIN, 20, 26);
        pulse_hit_stand(1'b0, 1'b1);
        give_card(10, 0);
        give_card(10, 0);
        wait_state(S_RESULT_WIN);

        // Reset in the middle of a dealer request.
        start_round(10, 6, 2, 16, 2);
        expect_st(S_DRAW_TO_17, 16, 2);
        pulse_hit_stand(1'b0, 1'b1);
        n = 0;
        while (!card_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(card_req == 1'b1 && gameState == S_DRAW_TO_17, "draw_req", int'(card_req), 1);
        expect_st(S_RESET, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        chk(gameState == S_RESET, "midreset_state", int'(gameState), int'(S_RESET));
        chk(playerHand == 0, "midreset_player", int'(playerHand), 0);
        chk(dealerHand == 0, "midreset_dealer", int'(dealerHand), 0);
        chk(card_req == 1'b0, "midreset_req", int'(card_req), 0);
        reset = 1'b0;

        repeat (4) @(negedge clk);
        chk(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
